// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data memory responder.
// Access encodings, FSM states and byte-lane mask constants.
package data_memory_responder_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  localparam logic [3:0] MASK_FULL = 4'b1111;
  localparam logic [3:0] MASK_LO16 = 4'b1100;
  localparam logic [3:0] MASK_HI16 = 4'b0011;

  // mask bit 3 selects lane 0 (bits 7:0), bit 0 selects lane 3
  function automatic logic [31:0] lane_expand(
    input logic [3:0] mask
  );
    logic [31:0] m;
    for (int k = 0; k < 4; k++)
      m[8*k +: 8] = {8{mask[3-k]}};
    return m;
  endfunction

endpackage

// File: rtl/data_memory_responder_byte_lane_aligner.sv
// Combinational byte-lane shifter/merger for loads and stores.
// Produces the merged store word and the right-aligned load data.
module byte_lane_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lmask;
  logic        w_single;
  logic [1:0]  w_lane;
  logic [4:0]  w_sh;

  assign w_lmask  = lane_expand(i_mask);
  assign w_single = $onehot(i_mask);
  assign w_sh     = {w_lane, 3'b000};

  // lane number of a single-lane mask
  always_comb begin
    w_lane = 2'd3;
    if (i_mask[3])      w_lane = 2'd0;
    else if (i_mask[2]) w_lane = 2'd1;
    else if (i_mask[1]) w_lane = 2'd2;
  end

  // store merge and load alignment; irregular masks work in place
  always_comb begin
    o_wword = (i_word & ~w_lmask) | (i_wdata & w_lmask);
    o_rdata = i_word & w_lmask;
    unique case (1'b1)
      (i_mask == MASK_FULL): begin
        o_wword = i_wdata;
        o_rdata = i_word;
      end
      (i_mask == MASK_LO16): begin
        o_wword = {i_word[31:16], i_wdata[15:0]};
        o_rdata = {16'h0, i_word[15:0]};
      end
      (i_mask == MASK_HI16): begin
        o_wword = {i_wdata[15:0], i_word[15:0]};
        o_rdata = {16'h0, i_word[31:16]};
      end
      w_single: begin
        o_wword = (i_word & ~w_lmask)
                | ({4{i_wdata[7:0]}} & w_lmask);
        o_rdata = {24'h0, 8'(i_word >> w_sh)};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency word memory answering a load/store initiator.
// Optional range check: define DATA_MEMORY_RANGE_CHECK_EN.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int LATENCY       = 2
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        memory_state,
  input  logic [3:0]  frame_mask,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        memory_done,
  output logic        busy
`ifdef DATA_MEMORY_RANGE_CHECK_EN
  ,
  output logic        access_error
`endif
);

  localparam int         DEPTH    = 2 ** ADDRESS_WIDTH;
  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_e                   r_state;
  state_e                   w_next;
  logic [3:0]               r_cnt;
  logic                     r_armed;
  logic                     w_accept;
  mem_op_e                  r_op;
  logic [3:0]               r_mask;
  logic [ADDRESS_WIDTH-1:0] r_idx;
  logic [31:0]              r_wdata;
  logic                     r_err;
  logic [31:0]              r_rdata;
  logic [31:0]              r_mem [0:DEPTH-1];

  mem_op_e                  w_op;
  logic [3:0]               w_mask;
  logic [ADDRESS_WIDTH-1:0] w_idx;
  logic [31:0]              w_wdata;
  logic                     w_err;
  logic                     w_err_in;
  logic                     w_fire;
  logic [31:0]              w_wword;
  logic [31:0]              w_rd;
  logic                     w_unused;

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  assign w_err_in = |(address >> (ADDRESS_WIDTH + 2));
`else
  assign w_err_in = 1'b0;
`endif

  assign w_unused = ^{address[1:0],
                      address >> (ADDRESS_WIDTH + 2)};

  // with LATENCY=1 the commit edge is the accept edge,
  // so the live inputs stand in for the capture registers
  assign w_op    = (r_state == ST_IDLE) ?
                   mem_op_e'(memory_state) : r_op;
  assign w_mask  = (r_state == ST_IDLE) ? frame_mask : r_mask;
  assign w_idx   = (r_state == ST_IDLE) ?
                   address[ADDRESS_WIDTH+1:2] : r_idx;
  assign w_wdata = (r_state == ST_IDLE) ? write_data : r_wdata;
  assign w_err   = (r_state == ST_IDLE) ? w_err_in : r_err;
  assign w_fire  = reset_n && (w_next == ST_RESPOND);

  byte_lane_aligner u_align (
    .i_mask  (w_mask),
    .i_word  (r_mem[w_idx]),
    .i_wdata (w_wdata),
    .o_wword (w_wword),
    .o_rdata (w_rd)
  );

  assign read_data   = r_rdata;
  assign memory_done = (r_state == ST_RESPOND);
  assign busy        = (r_state != ST_IDLE);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
  assign access_error = memory_done && r_err;
`endif

  // next-state: accept once per enable assertion, then count out latency
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable && r_armed) begin
          w_accept = 1'b1;
          w_next   = (LATENCY == 1) ? ST_RESPOND : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_LAST) w_next = ST_RESPOND;
      end
      ST_RESPOND: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // state, latency counter, re-arm flag and request capture
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_armed <= 1'b1;
      r_op    <= MEM_READ;
      r_mask  <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!enable) r_armed <= 1'b1;
      if (w_accept) begin
        r_armed <= 1'b0;
        r_cnt   <= 4'd1;
        r_op    <= mem_op_e'(memory_state);
        r_mask  <= frame_mask;
        r_idx   <= address[ADDRESS_WIDTH+1:2];
        r_wdata <= write_data;
        r_err   <= w_err_in;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (r_state == ST_RESPOND) begin
        r_cnt <= 4'd0;
      end
    end
  end

  // load result registered on the edge entering RESPOND
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'd0;
    end else if (w_fire && w_op == MEM_READ) begin
      r_rdata <= w_err ? 32'd0 : w_rd;
    end
  end

  // storage is not reset; stores commit on the edge entering RESPOND
  always_ff @(posedge CLK) begin
    if (w_fire && w_op == MEM_WRITE && !w_err)
      r_mem[w_idx] <= w_wword;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder.
// Directed vectors; monitor pops expectations on memory_done.
module tb_data_memory_responder;

  localparam int AW = 8;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        en1;
  logic        memory_state;
  logic [3:0]  frame_mask;
  logic [31:0] address;
  logic [31:0] write_data;
  wire  [31:0] read_data;
  wire  [31:0] read_data1;
  wire         memory_done;
  wire         busy;
  wire         done1;
  wire         busy1;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
  wire         access_error;
  wire         err1;
`endif

  data_memory_responder #(.ADDRESS_WIDTH(AW), .LATENCY(2)) u_dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .enable       (enable),
    .memory_state (memory_state),
    .frame_mask   (frame_mask),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .memory_done  (memory_done),
    .busy         (busy)
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    ,
    .access_error (access_error)
`endif
  );

  data_memory_responder #(.ADDRESS_WIDTH(AW), .LATENCY(1)) u_dut1 (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .enable       (en1),
    .memory_state (memory_state),
    .frame_mask   (frame_mask),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data1),
    .memory_done  (done1),
    .busy         (busy1)
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    ,
    .access_error (err1)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    int          at;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every completion must match the oldest expectation
  always @(negedge CLK) begin
    if (reset_n === 1'b1 && memory_done === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_done: got pulse at %0d want none",
                 cyc);
      end else begin
        m_e = q.pop_front();
        check("rdata", read_data, m_e.rd);
        check("latency", 32'(cyc), 32'(m_e.at));
        check("busy_in_respond", {31'd0, busy}, 32'd1);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
        check("access_error", {31'd0, access_error},
              {31'd0, m_e.err});
`endif
      end
    end
  end

  // one request on the LATENCY=2 instance; inputs scrambled after accept
  task automatic req(input bit wr,
                     input logic [3:0] m,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] rd_exp,
                     input bit err = 1'b0);
    exp_t e;
    @(negedge CLK);
    memory_state = wr;
    frame_mask   = m;
    address      = a;
    write_data   = wd;
    enable       = 1'b1;
    if (!wr) last_rd = rd_exp;
    e.rd  = last_rd;
    e.at  = cyc + 2;
    e.err = err;
    q.push_back(e);
    @(negedge CLK);
    enable       = 1'b0;
    check("busy_in_wait", {31'd0, busy}, 32'd1);
    memory_state = ~wr;
    frame_mask   = ~m;
    address      = $urandom;
    write_data   = $urandom;
    for (int i = 0; i < 20 && (busy || q.size() != 0); i++)
      @(negedge CLK);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got no done want done for %h", a);
      q.delete();
    end
  endtask

  // one request on the LATENCY=1 instance
  task automatic l1(input bit wr,
                    input logic [3:0] m,
                    input logic [31:0] a,
                    input logic [31:0] wd,
                    input logic [31:0] rd_exp,
                    input string nm);
    @(negedge CLK);
    memory_state = wr;
    frame_mask   = m;
    address      = a;
    write_data   = wd;
    en1          = 1'b1;
    @(negedge CLK);
    check({nm, "_done"}, {31'd0, done1}, 32'd1);
    if (!wr) check(nm, read_data1, rd_exp);
    en1 = 1'b0;
    @(negedge CLK);
    check({nm, "_done_end"}, {31'd0, done1}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset_n      = 1'b0;
    enable       = 1'b0;
    en1          = 1'b0;
    memory_state = 1'b0;
    frame_mask   = 4'd0;
    address      = 32'd0;
    write_data   = 32'd0;
    #1;
    check("rst_rdata", read_data, 32'd0);
    check("rst_done", {31'd0, memory_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done1", {31'd0, done1}, 32'd0);
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;

    req(1, 4'b1111, 32'h10, 32'hDEADBEEF, 0);
    req(0, 4'b1111, 32'h10, 0, 32'hDEADBEEF);
    req(1, 4'b1111, 32'h10, 32'h11223344, 0);
    req(1, 4'b0010, 32'h12, 32'h000000A5, 0);
    req(0, 4'b1111, 32'h10, 0, 32'h11A53344);
    req(0, 4'b0010, 32'h12, 0, 32'h000000A5);

    req(1, 4'b1111, 32'h20, 32'hCAFEF00D, 0);
    req(0, 4'b0011, 32'h20, 0, 32'h0000CAFE);
    req(0, 4'b1100, 32'h20, 0, 32'h0000F00D);
    req(0, 4'b0100, 32'h20, 0, 32'h000000F0);
    req(0, 4'b1000, 32'h20, 0, 32'h0000000D);
    req(0, 4'b0001, 32'h20, 0, 32'h000000CA);
    req(0, 4'b1010, 32'h20, 0, 32'h00FE000D);
    req(0, 4'b0000, 32'h20, 0, 32'h00000000);
    req(1, 4'b0000, 32'h20, 32'hFFFFFFFF, 0);
    req(0, 4'b1111, 32'h20, 0, 32'hCAFEF00D);
    req(1, 4'b0101, 32'h20, 32'h11223344, 0);
    req(0, 4'b1111, 32'h20, 0, 32'h11FE330D);

    req(1, 4'b1111, 32'h24, 32'h55667788, 0);
    req(1, 4'b1100, 32'h24, 32'hAAAA1234, 0);
    req(1, 4'b0011, 32'h24, 32'hBBBB9ABC, 0);
    req(0, 4'b1111, 32'h24, 0, 32'h9ABC1234);
    req(1, 4'b1000, 32'h24, 32'h000000EE, 0);
    req(0, 4'b1111, 32'h24, 0, 32'h9ABC12EE);

    req(1, 4'b1111, 32'h0, 32'h01020304, 0);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    req(1, 4'b1111, 32'h400, 32'h99999999, 0, 1'b1);
    req(0, 4'b1111, 32'h0, 0, 32'h01020304);
    req(0, 4'b1111, 32'h400, 0, 32'h00000000, 1'b1);
`else
    req(1, 4'b1111, 32'h400, 32'h99999999, 0);
    req(0, 4'b1111, 32'h0, 0, 32'h99999999);
`endif

    req(1, 4'b1111, 32'h30, 32'h0BADF00D, 0);
    @(negedge CLK);
    memory_state = 1'b1;
    frame_mask   = 4'b1111;
    address      = 32'h30;
    write_data   = 32'h12345678;
    enable       = 1'b1;
    @(negedge CLK);
    enable  = 1'b0;
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, memory_done}, 32'd0);
    check("abort_rdata", read_data, 32'd0);
    last_rd = 32'd0;
    @(negedge CLK);
    reset_n = 1'b1;
    repeat (4) @(negedge CLK);
    req(0, 4'b1111, 32'h30, 0, 32'h0BADF00D);

    l1(1, 4'b1111, 32'h40, 32'hCAFEF00D, 0, "l1_wr");
    l1(0, 4'b0011, 32'h40, 0, 32'h0000CAFE, "l1_rd_hi");
    l1(0, 4'b0100, 32'h40, 0, 32'h000000F0, "l1_rd_lane1");

    @(negedge CLK);
    frame_mask = 4'b1111;
    memory_state = 1'b0;
    en1    = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge CLK);
      if (done1) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    en1 = 1'b0;
    @(negedge CLK);
    en1    = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge CLK);
      if (done1) pulses++;
    end
    check("rearm_pulses", 32'(pulses), 32'd1);
    en1 = 1'b0;
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
